// File: rtl/regfile_alu_datapath.sv
// Register-file + ALU datapath slave for the Lab3 sequencer.
// One register-to-register micro-op per clock. All sequencing comes from the
// control word supplied by the control unit; this block has no FSM.
module regfile_alu_datapath #(
   parameter int DATA_WIDTH = 16
) (
   input  logic                  Clk_i,
   input  logic                  nReset_i,
   input  logic                  InputEn_i,
   input  logic                  WriteEn_i,
   input  logic [2:0]            WriteAddr_i,
   input  logic [2:0]            ReadAddr_A_i,
   input  logic [2:0]            ReadAddr_B_i,
   input  logic [1:0]            ALUOpcode_i,
   input  logic [1:0]            SHAMT_i,
   input  logic                  OutputEn_i,
   input  logic [DATA_WIDTH-1:0] Data_i,
   output logic [DATA_WIDTH-1:0] Data_o,
   output logic                  Done_o,
   output logic                  Ovf_o
);

   localparam int NUM_REGS = 8;
   localparam int MSB      = DATA_WIDTH - 1;

   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_SHL = 2'b01;
   localparam logic [1:0] OP_SUB = 2'b10;
   localparam logic [1:0] OP_AND = 2'b11;

   // Control word as issued by the sequencer for the current state.
   typedef struct packed {
      logic       inputEn;
      logic       writeEn;
      logic [2:0] writeAddr;
      logic [2:0] readAddrA;
      logic [2:0] readAddrB;
      logic [1:0] aluOp;
      logic [1:0] shamt;
      logic       outputEn;
   } ctrlWord_t;

   ctrlWord_t ctrl;

   // Register file. Entry 0 exists only as an index; it is never written and
   // every read of address 0 is forced to zero by the read muxes.
   logic [NUM_REGS-1:0][DATA_WIDTH-1:0] regs;

   logic [DATA_WIDTH-1:0] opA;
   logic [DATA_WIDTH-1:0] opB;
   logic [DATA_WIDTH-1:0] aluResult;
   logic [DATA_WIDTH-1:0] wrData;
   logic                  arithOvf;
   logic                  wrHit;

   assign ctrl = '{
      inputEn:   InputEn_i,
      writeEn:   WriteEn_i,
      writeAddr: WriteAddr_i,
      readAddrA: ReadAddr_A_i,
      readAddrB: ReadAddr_B_i,
      aluOp:     ALUOpcode_i,
      shamt:     SHAMT_i,
      outputEn:  OutputEn_i
   };

   // Operand read ports: combinational, return the pre-edge value (no bypass),
   // which is what lets Rn <= Rm + Rn work in a single state.
   always_comb begin
      opA = '0;
      opB = '0;
      for (int i = 1; i < NUM_REGS; i++) begin
         if (ctrl.readAddrA == 3'(i)) opA = regs[i];
         if (ctrl.readAddrB == 3'(i)) opB = regs[i];
      end
   end

   // ALU: truncating two's-complement arithmetic plus shift and AND.
   always_comb begin
      aluResult = '0;
      unique case (ctrl.aluOp)
         OP_ADD: aluResult = opA + opB;
         OP_SHL: aluResult = opA << ctrl.shamt;
         OP_SUB: aluResult = opA - opB;
         OP_AND: aluResult = opA & opB;
         default: aluResult = '0;
      endcase
   end

   // Signed overflow: add overflows when operand signs match and the result
   // sign differs; subtract when operand signs differ and the result sign
   // differs from A. Shift and AND never report overflow.
   always_comb begin
      arithOvf = 1'b0;
      unique case (ctrl.aluOp)
         OP_ADD:  arithOvf = (opA[MSB] == opB[MSB]) && (aluResult[MSB] != opA[MSB]);
         OP_SUB:  arithOvf = (opA[MSB] != opB[MSB]) && (aluResult[MSB] != opA[MSB]);
         default: arithOvf = 1'b0;
      endcase
   end

   assign wrData = ctrl.inputEn ? Data_i : aluResult;
   assign wrHit  = ctrl.writeEn && (ctrl.writeAddr != 3'd0);

   // Write-back: one destination per edge, address 0 silently dropped.
   always_ff @(posedge Clk_i or negedge nReset_i) begin
      if (!nReset_i) begin
         regs <= '0;
      end else if (wrHit) begin
         for (int i = 1; i < NUM_REGS; i++) begin
            if (ctrl.writeAddr == 3'(i)) regs[i] <= wrData;
         end
      end
   end

   // Output port: capture the ALU result and pulse Done_o for each enabled edge.
   always_ff @(posedge Clk_i or negedge nReset_i) begin
      if (!nReset_i) begin
         Data_o <= '0;
         Done_o <= 1'b0;
      end else begin
         Done_o <= ctrl.outputEn;
         if (ctrl.outputEn) Data_o <= aluResult;
      end
   end

   // Sticky overflow: any ALU write-back that overflows, including one aimed
   // at R0, sets it; only reset clears it.
   always_ff @(posedge Clk_i or negedge nReset_i) begin
      if (!nReset_i) begin
         Ovf_o <= 1'b0;
      end else if (ctrl.writeEn && !ctrl.inputEn && arithOvf) begin
         Ovf_o <= 1'b1;
      end
   end

endmodule

// File: tb/tb_regfile_alu_datapath.sv
// Scoreboard bench for regfile_alu_datapath: a reference register model
// predicts each captured result; predictions are queued when OutputEn_i is
// driven and popped when Done_o is observed.
module tb_regfile_alu_datapath;

   localparam int DW = 16;

   logic          Clk_i = 1'b0;
   logic          nReset_i;
   logic          InputEn_i, WriteEn_i, OutputEn_i;
   logic [2:0]    WriteAddr_i, ReadAddr_A_i, ReadAddr_B_i;
   logic [1:0]    ALUOpcode_i, SHAMT_i;
   logic [DW-1:0] Data_i, Data_o;
   logic          Done_o, Ovf_o;

   int total = 0;
   int bad   = 0;

   logic [DW-1:0] refR [8];
   logic          refOvf;
   logic [DW-1:0] sbQ [$];

   regfile_alu_datapath #(.DATA_WIDTH(DW)) dut (
      .Clk_i(Clk_i), .nReset_i(nReset_i),
      .InputEn_i(InputEn_i), .WriteEn_i(WriteEn_i), .WriteAddr_i(WriteAddr_i),
      .ReadAddr_A_i(ReadAddr_A_i), .ReadAddr_B_i(ReadAddr_B_i),
      .ALUOpcode_i(ALUOpcode_i), .SHAMT_i(SHAMT_i), .OutputEn_i(OutputEn_i),
      .Data_i(Data_i), .Data_o(Data_o), .Done_o(Done_o), .Ovf_o(Ovf_o)
   );

   always #5 Clk_i = ~Clk_i;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [DW-1:0] refAlu(input logic [1:0] op, input logic [DW-1:0] a,
                                            input logic [DW-1:0] b, input logic [1:0] sh);
      logic [31:0] t;
      case (op)
         2'b00: t = 32'(a) + 32'(b);
         2'b01: t = 32'(a) << sh;
         2'b10: t = 32'(a) - 32'(b);
         default: t = 32'(a & b);
      endcase
      return t[DW-1:0];
   endfunction

   function automatic logic refOvfOf(input logic [1:0] op, input logic [DW-1:0] a,
                                     input logic [DW-1:0] b);
      int sa, sb, r;
      sa = int'($signed(a));
      sb = int'($signed(b));
      if (op == 2'b00)      r = sa + sb;
      else if (op == 2'b10) r = sa - sb;
      else                  return 1'b0;
      return (r > 32767) || (r < -32768);
   endfunction

   task automatic setIdle();
      InputEn_i = 0; WriteEn_i = 0; WriteAddr_i = 0; ReadAddr_A_i = 0; ReadAddr_B_i = 0;
      ALUOpcode_i = 0; SHAMT_i = 0; OutputEn_i = 0; Data_i = 0;
   endtask

   task automatic modelReset();
      for (int i = 0; i < 8; i++) refR[i] = '0;
      refOvf = 1'b0;
      sbQ.delete();
   endtask

   // One micro-op: drive, predict, clock, then check outputs 1 time unit later.
   task automatic drive(input logic ie, input logic we, input logic [2:0] wa,
                        input logic [2:0] ra, input logic [2:0] rb, input logic [1:0] op,
                        input logic [1:0] sh, input logic oe, input logic [DW-1:0] d);
      logic [DW-1:0] res;
      res = refAlu(op, refR[ra], refR[rb], sh);
      if (oe) sbQ.push_back(res);
      InputEn_i = ie; WriteEn_i = we; WriteAddr_i = wa; ReadAddr_A_i = ra;
      ReadAddr_B_i = rb; ALUOpcode_i = op; SHAMT_i = sh; OutputEn_i = oe; Data_i = d;
      if (we && !ie && refOvfOf(op, refR[ra], refR[rb])) refOvf = 1'b1;
      if (we && wa != 3'd0) refR[wa] = ie ? d : res;
      @(posedge Clk_i);
      #1;
      chk("done", 32'(Done_o), 32'(oe));
      chk("ovf", 32'(Ovf_o), 32'(refOvf));
      if (Done_o) begin
         if (sbQ.size() == 0) chk("sbEmpty", 32'(1), 32'(0));
         else chk("dataO", 32'(Data_o), 32'(sbQ.pop_front()));
      end
      setIdle();
   endtask

   task automatic load(input logic [2:0] wa, input logic [DW-1:0] d);
      drive(1, 1, wa, 0, 0, 2'b00, 0, 0, d);
   endtask

   // Expose a register on Data_o via A&A and compare against a spec constant too.
   task automatic readReg(input string tag, input logic [2:0] ra, input logic [DW-1:0] exp);
      drive(0, 0, 0, ra, ra, 2'b11, 0, 1, '0);
      chk(tag, 32'(Data_o), 32'(exp));
   endtask

   task automatic asyncReset();
      nReset_i = 1'b0;
      #1;
      modelReset();
      chk("rstData", 32'(Data_o), 32'(0));
      chk("rstDone", 32'(Done_o), 32'(0));
      chk("rstOvf", 32'(Ovf_o), 32'(0));
      @(posedge Clk_i);
      #2;
      nReset_i = 1'b1;
   endtask

   initial begin
      setIdle();
      modelReset();
      nReset_i = 1'b0;
      #12;
      chk("initData", 32'(Data_o), 32'(0));
      chk("initDone", 32'(Done_o), 32'(0));
      chk("initOvf", 32'(Ovf_o), 32'(0));
      nReset_i = 1'b1;

      // Overflow on add, with write and capture on the same edge; stays sticky.
      load(1, 16'h7FFF);
      load(2, 16'h0001);
      drive(0, 1, 3, 1, 2, 2'b00, 0, 1, '0);
      chk("ovfSum", 32'(Data_o), 32'h8000);
      chk("ovfSet", 32'(Ovf_o), 32'(1));
      readReg("r3Ovf", 3, 16'h8000);
      drive(0, 1, 4, 2, 2, 2'b00, 0, 0, '0);
      chk("ovfSticky", 32'(Ovf_o), 32'(1));

      // Reset mid-run with R1 loaded and Data_o/Ovf_o non-zero.
      load(1, 16'd5);
      asyncReset();
      readReg("r1AfterRst", 1, 16'h0000);
      readReg("r3AfterRst", 3, 16'h0000);

      // Subtract overflow from fresh state, written to R0: still sets the flag.
      load(1, 16'h8000);
      load(2, 16'h0001);
      drive(0, 1, 0, 1, 2, 2'b10, 0, 0, '0);
      chk("subOvf", 32'(Ovf_o), 32'(1));
      asyncReset();

      // R0 is hard zero.
      load(0, 16'h1234);
      drive(0, 0, 0, 0, 0, 2'b00, 0, 1, '0);
      chk("r0Zero", 32'(Data_o), 32'(0));

      // InputEn without WriteEn changes nothing.
      load(5, 16'h00A5);
      drive(1, 0, 5, 0, 0, 2'b00, 0, 0, 16'hFFFF);
      readReg("r5Hold", 5, 16'h00A5);

      // Shift by 0..3 with OutputEn held four cycles; shifts never flag overflow.
      load(1, 16'hC001);
      for (int s = 0; s < 4; s++) drive(0, 1, 2, 1, 0, 2'b01, 2'(s), 1, '0);
      chk("shlOvf", 32'(Ovf_o), 32'(0));
      readReg("shl3", 2, 16'h0008);

      // Same-register hazard: R1 <= R1 + R1 twice.
      load(1, 16'd3);
      drive(0, 1, 1, 1, 1, 2'b00, 0, 0, '0);
      readReg("hz6", 1, 16'd6);
      drive(0, 1, 1, 1, 1, 2'b00, 0, 0, '0);
      readReg("hz12", 1, 16'd12);

      // Full 15-state sequence (S0 idle, S1..S14).
      asyncReset();
      drive(0, 0, 0, 0, 0, 2'b00, 0, 0, '0);           // S0
      load(1, 16'd1);                                  // S1
      load(2, 16'd2);                                  // S2
      load(3, 16'd3);                                  // S3
      load(4, 16'd40);                                 // S4
      drive(0, 1, 5, 1, 2, 2'b00, 0, 0, '0);           // S5  R5=R1+R2=3
      drive(0, 1, 6, 5, 0, 2'b01, 1, 0, '0);           // S6  R6=R5<<1=6
      drive(0, 1, 1, 6, 5, 2'b00, 0, 0, '0);           // S7  R1=R6+R5=9
      drive(0, 1, 2, 3, 0, 2'b01, 2, 0, '0);           // S8  R2=R3<<2=12
      drive(0, 1, 3, 2, 2, 2'b11, 0, 0, '0);           // S9  R3=R2&R2=12
      drive(0, 1, 7, 4, 1, 2'b10, 0, 0, '0);           // S10 R7=R4-R1=31
      drive(0, 1, 5, 7, 3, 2'b11, 0, 0, '0);           // S11 R5=R7&R3=12
      drive(0, 1, 6, 5, 3, 2'b10, 0, 0, '0);           // S12 R6=R5-R3=0
      drive(0, 1, 6, 6, 7, 2'b00, 0, 0, '0);           // S13 R6=R6+R7=31
      drive(0, 0, 0, 7, 0, 2'b00, 0, 1, '0);           // S14 Data_o=R7+R0
      chk("s14Data", 32'(Data_o), 32'd31);
      drive(0, 0, 0, 0, 0, 2'b00, 0, 0, '0);           // back to S0: pulse ends
      chk("s14Hold", 32'(Data_o), 32'd31);
      readReg("seqR1", 1, 16'd9);
      readReg("seqR2", 2, 16'd12);
      readReg("seqR3", 3, 16'd12);
      readReg("seqR7", 7, 16'd31);
      readReg("seqR6", 6, 16'd31);

      chk("sbDrained", 32'(sbQ.size()), 32'(0));
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
